xpose_addr_seq: RTL and testbench

//  Address sequencer for the matrix-transpose datapath: steps the ART/ARG (read) and AWT/AWG (write)

---
 rtl/xpose_addr_seq.sv | 149 ++++++++++++++
 tb/tb_xpose_addr_seq.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/xpose_addr_seq.sv
// Address sequencer for the matrix-transpose datapath: walks a rows x cols traversal,
// issuing one reset-select code per cycle plus ART/ARG/AWT/AWG increment strobes.
module xpose_addr_seq #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [CW-1:0] rows,
  input  logic [CW-1:0] cols,
  input  logic          rd_ack,
  input  logic          wr_ack,
  output logic [2:0]    rst_sel,
  output logic          inc_art,
  output logic          inc_arg,
  output logic          inc_awt,
  output logic          inc_awg,
  output logic          rd_req,
  output logic          wr_req,
  output logic          busy,
  output logic          done
);

  localparam logic [2:0] RS_NONE = 3'd0;
  localparam logic [2:0] RS_ART  = 3'd1;
  localparam logic [2:0] RS_AWG  = 3'd4;
  localparam logic [2:0] RS_MDAR = 3'd5;
  localparam logic [2:0] RS_ALL  = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_RD, S_WR, S_ADV, S_WRAP_R, S_WRAP_W, S_FIN
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] r_q, r_d;
  logic [CW-1:0] c_q, c_d;
  logic [CW-1:0] rows_q, rows_d;
  logic [CW-1:0] cols_q, cols_d;
  logic [CW-1:0] rows_last, cols_last;

  // Last-index values stay in CW bits so a dimension of 2^CW-1 compares correctly.
  assign rows_last = rows_q - CW'(1);
  assign cols_last = cols_q - CW'(1);
  assign busy      = (state_q != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      c_q     <= '0;
      rows_q  <= '0;
      cols_q  <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      c_q     <= c_d;
      rows_q  <= rows_d;
      cols_q  <= cols_d;
    end
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    c_d     = c_q;
    rows_d  = rows_q;
    cols_d  = cols_q;
    rst_sel = RS_NONE;
    inc_art = 1'b0;
    inc_arg = 1'b0;
    inc_awt = 1'b0;
    inc_awg = 1'b0;
    rd_req  = 1'b0;
    wr_req  = 1'b0;
    done    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          rows_d  = rows;
          cols_d  = cols;
          r_d     = '0;
          c_d     = '0;
          state_d = S_CLR;
        end
      end
      S_CLR: begin
        rst_sel = RS_ALL;
        state_d = (rows_q == '0 || cols_q == '0) ? S_FIN : S_RD;
      end
      S_RD: begin
        rd_req = 1'b1;
        if (rd_ack) state_d = S_WR;
      end
      S_WR: begin
        wr_req = 1'b1;
        if (wr_ack) state_d = S_ADV;
      end
      S_ADV: begin
        if (c_q < cols_last) begin
          inc_art = 1'b1;
          inc_awg = 1'b1;
          c_d     = c_q + CW'(1);
          state_d = S_RD;
        end else if (r_q < rows_last) begin
          state_d = S_WRAP_R;
        end else begin
          state_d = S_FIN;
        end
      end
      // Row end needs two resets; one code per cycle, so split across two states.
      S_WRAP_R: begin
        rst_sel = RS_ART;
        inc_arg = 1'b1;
        state_d = S_WRAP_W;
      end
      S_WRAP_W: begin
        rst_sel = RS_AWG;
        inc_awt = 1'b1;
        c_d     = '0;
        r_d     = r_q + CW'(1);
        state_d = S_RD;
      end
      S_FIN: begin
        rst_sel = RS_MDAR;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort replaces this cycle's outputs with a full reset and wins over any ack.
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      r_d     = '0;
      c_d     = '0;
      rst_sel = RS_ALL;
      inc_art = 1'b0;
      inc_arg = 1'b0;
      inc_awt = 1'b0;
      inc_awg = 1'b0;
      rd_req  = 1'b0;
      wr_req  = 1'b0;
      done    = 1'b0;
    end
  end

endmodule

// File: tb/tb_xpose_addr_seq.sv
// Randomized bench for xpose_addr_seq: a loop-based trace model expands each traversal
// into the expected per-cycle output vector and the bench replays it against the DUT.
module tb_xpose_addr_seq;

  localparam int CW = 8;
  localparam logic [2:0] RS_NONE = 3'd0;
  localparam logic [2:0] RS_ART  = 3'd1;
  localparam logic [2:0] RS_AWG  = 3'd4;
  localparam logic [2:0] RS_MDAR = 3'd5;
  localparam logic [2:0] RS_ALL  = 3'd7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [CW-1:0] rows = '0;
  logic [CW-1:0] cols = '0;
  logic          rd_ack = 1'b0;
  logic          wr_ack = 1'b0;
  logic [2:0]    rst_sel;
  logic          inc_art, inc_arg, inc_awt, inc_awg;
  logic          rd_req, wr_req, busy, done;

  xpose_addr_seq #(.CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .rows(rows), .cols(cols), .rd_ack(rd_ack), .wr_ack(wr_ack),
    .rst_sel(rst_sel), .inc_art(inc_art), .inc_arg(inc_arg),
    .inc_awt(inc_awt), .inc_awg(inc_awg), .rd_req(rd_req),
    .wr_req(wr_req), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Output vector layout: busy, done, rst_sel[2:0], inc_art, inc_arg, inc_awt, inc_awg, rd_req, wr_req
  function automatic logic [10:0] obs();
    return {busy, done, rst_sel, inc_art, inc_arg, inc_awt, inc_awg, rd_req, wr_req};
  endfunction

  function automatic logic [10:0] mk(bit b, bit d, logic [2:0] sel, bit ia, bit ig,
                                     bit it, bit iw, bit rq, bit wq);
    return {b, d, sel, ia, ig, it, iw, rq, wq};
  endfunction

  typedef struct {
    logic [10:0] o;
    bit st;
    bit ab;
    bit ra;
    bit wa;
  } ent_t;

  ent_t tq[$];

  function automatic void push(logic [10:0] o, bit st, bit ab, bit ra, bit wa);
    ent_t e;
    e.o = o; e.st = st; e.ab = ab; e.ra = ra; e.wa = wa;
    tq.push_back(e);
  endfunction

  function automatic bit rb();
    return bit'($urandom_range(1, 0));
  endfunction

  // Expand one traversal into its expected cycle trace, optionally abort it, then replay.
  task automatic run(string nm, int rws, int cls, int rd_lo, int rd_hi,
                     int wr_lo, int wr_hi, int amode);
    int a;
    int nbusy;
    int dly;
    logic [10:0] idle_v;
    idle_v = '0;
    tq.delete();
    push(idle_v, 1'b1, 1'b0, rb(), rb());
    push(mk(1, 0, RS_ALL, 0, 0, 0, 0, 0, 0), rb(), 1'b0, rb(), rb());
    if (rws == 0 || cls == 0) begin
      push(mk(1, 1, RS_MDAR, 0, 0, 0, 0, 0, 0), rb(), 1'b0, rb(), rb());
    end else begin
      for (int r = 0; r < rws; r++) begin
        for (int c = 0; c < cls; c++) begin
          dly = $urandom_range(rd_hi, rd_lo);
          for (int k = 0; k <= dly; k++)
            push(mk(1, 0, RS_NONE, 0, 0, 0, 0, 1, 0), rb(), 1'b0, (k == dly), rb());
          dly = $urandom_range(wr_hi, wr_lo);
          for (int k = 0; k <= dly; k++)
            push(mk(1, 0, RS_NONE, 0, 0, 0, 0, 0, 1), rb(), 1'b0, rb(), (k == dly));
          if (c < cls - 1) begin
            push(mk(1, 0, RS_NONE, 1, 0, 0, 1, 0, 0), rb(), 1'b0, rb(), rb());
          end else begin
            push(mk(1, 0, RS_NONE, 0, 0, 0, 0, 0, 0), rb(), 1'b0, rb(), rb());
            if (r < rws - 1) begin
              push(mk(1, 0, RS_ART, 0, 1, 0, 0, 0, 0), rb(), 1'b0, rb(), rb());
              push(mk(1, 0, RS_AWG, 0, 0, 1, 0, 0, 0), rb(), 1'b0, rb(), rb());
            end else begin
              push(mk(1, 1, RS_MDAR, 0, 0, 0, 0, 0, 0), rb(), 1'b0, rb(), rb());
            end
          end
        end
      end
    end

    a = -1;
    if (amode == 1) begin
      a = $urandom_range(tq.size() - 1, 1);
    end else if (amode == 2) begin
      for (int i = 1; i < tq.size(); i++)
        if (a < 0 && tq[i].o[0] && tq[i].wa) a = i;
    end
    if (a > 0) begin
      while (tq.size() > a + 1) void'(tq.pop_back());
      tq[a].o  = mk(1, 0, RS_ALL, 0, 0, 0, 0, 0, 0);
      tq[a].ab = 1'b1;
    end
    // Quiet tail: start+abort together and abort alone in IDLE must do nothing.
    push(idle_v, 1'b1, 1'b1, rb(), rb());
    push(idle_v, 1'b0, 1'b1, rb(), rb());
    push(idle_v, 1'b0, 1'b0, 1'b0, 1'b0);

    nbusy = 0;
    for (int i = 0; i < tq.size(); i++) begin
      @(negedge clk);
      start  = tq[i].st;
      abort  = tq[i].ab;
      rd_ack = tq[i].ra;
      wr_ack = tq[i].wa;
      rows   = (i == 0) ? CW'(rws) : CW'($urandom);
      cols   = (i == 0) ? CW'(cls) : CW'($urandom);
      #1;
      if (busy) nbusy++;
      chk($sformatf("%s cyc%0d", nm, i), 32'(obs()), 32'(tq[i].o));
    end
    if (amode == 0 && rd_hi == 0 && wr_hi == 0)
      chk($sformatf("%s busylen", nm), nbusy,
          (rws == 0 || cls == 0) ? 2 : 3 * rws * cls + 2 * (rws - 1) + 2);
  endtask

  initial begin
    #1;
    chk("reset vec", 32'(obs()), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post reset vec", 32'(obs()), 32'd0);

    run("r2c3", 2, 3, 0, 0, 0, 0, 0);
    run("r1c1", 1, 1, 0, 0, 0, 0, 0);
    run("r0c4", 0, 4, 0, 0, 0, 0, 0);
    run("r2c2 rddly3", 2, 2, 3, 3, 0, 0, 0);
    run("abort wr", 2, 2, 0, 0, 0, 1, 2);
    run("restart", 2, 2, 0, 0, 0, 0, 0);
    run("r1c255", 1, 255, 0, 0, 0, 0, 0);
    run("r255c1", 255, 1, 0, 0, 0, 0, 0);

    // Asynchronous reset while a read is pending.
    @(negedge clk);
    start = 1'b1; rows = 8'd2; cols = 8'd2; rd_ack = 1'b0; wr_ack = 1'b0; abort = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #1;
    chk("pre-rst in RD", 32'(obs()), 32'(mk(1, 0, RS_NONE, 0, 0, 0, 0, 1, 0)));
    rst_n = 1'b0;
    #1;
    chk("async rst vec", 32'(obs()), 32'd0);
    @(negedge clk);
    start = 1'b1;
    #1;
    chk("start in rst", 32'(obs()), 32'd0);
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("idle after rst", 32'(obs()), 32'd0);
    run("after rst", 1, 2, 0, 0, 0, 0, 0);

    for (int n = 0; n < 30; n++) begin
      run($sformatf("rnd%0d", n), $urandom_range(4, 0), $urandom_range(4, 0),
          0, $urandom_range(2, 0), 0, $urandom_range(2, 0),
          ($urandom_range(9, 0) < 3) ? 1 : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
